// File: rtl/dt_walker.sv
// Decision-tree traversal engine: walks node memory from node 0 to a leaf and
// returns an ACCEPT/DROP verdict. Define DT_DEPTH_EN to expose out_depth.
module dt_walker #(
  parameter int N_FEAT    = 14,
  parameter int FEAT_W    = 16,
  parameter int N_NODES   = 73,
  parameter int MAX_STEPS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic [7:0]               mem_addr,
  input  logic [31:0]              mem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_accept,
`ifdef DT_DEPTH_EN
  output logic [7:0]               out_depth,
`endif
  output logic                     out_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  localparam logic [7:0] NODES_L = 8'(N_NODES);
  localparam logic [7:0] STEPS_L = 8'(MAX_STEPS);
  localparam logic [4:0] FEAT_L  = 5'(N_FEAT);

  state_t                    state_q;
  logic [N_FEAT*FEAT_W-1:0]  feat_q;
  logic [7:0]                mem_addr_q, steps_q, steps_d, next_d;
  logic                      in_ready_q, out_valid_q, out_accept_q, out_err_q;

  logic [3:0]        idx, lcode;
  logic [FEAT_W-1:0] thr, feat_sel;
  logic [7:0]        rchild;
  logic              is_leaf, bad_idx, go_left;

  assign idx     = mem_data[31:28];
  assign thr     = mem_data[27:12];
  assign lcode   = mem_data[11:8];
  assign rchild  = mem_data[7:0];
  assign is_leaf = (idx == 4'hF);
  assign bad_idx = ({1'b0, idx} >= FEAT_L);

  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < N_FEAT; i++)
      if (idx == 4'(i)) feat_sel = feat_q[i*FEAT_W +: FEAT_W];
  end

  // Left code 0 means the fall-through child; 8-bit add wraps 255 -> 0.
  assign go_left = (feat_sel < thr);
  assign next_d  = go_left ? ((lcode == 4'h0) ? mem_addr_q + 8'd1 : {4'h0, lcode})
                           : rchild;
  assign steps_d = steps_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      feat_q       <= '0;
      mem_addr_q   <= '0;
      steps_q      <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_accept_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          feat_q     <= in_feat;
          mem_addr_q <= '0;
          steps_q    <= '0;
          in_ready_q <= 1'b0;
          state_q    <= FETCH;
        end
        FETCH: state_q <= EVAL;
        EVAL: begin
          if (is_leaf) begin
            out_accept_q <= (lcode == 4'hF);
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else if (bad_idx) begin
            out_accept_q <= 1'b0;
            out_err_q    <= 1'b1;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            steps_q <= steps_d;
            if (next_d >= NODES_L || steps_d == STEPS_L) begin
              out_accept_q <= 1'b0;
              out_err_q    <= 1'b1;
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end else begin
              mem_addr_q <= next_d;
              state_q    <= FETCH;
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_addr   = mem_addr_q;
  assign out_valid  = out_valid_q;
  assign out_accept = out_accept_q;
  assign out_err    = out_err_q;
`ifdef DT_DEPTH_EN
  assign out_depth  = steps_q;
`endif

endmodule

// File: tb/tb_dt_walker.sv
// Scoreboard bench for dt_walker: stimulus pushes expected verdicts, a negedge
// monitor pops and compares verdict, error flag and latency.
module tb_dt_walker;
  localparam int N_FEAT = 14;
  localparam int FEAT_W = 16;
  localparam int FV_W   = N_FEAT*FEAT_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, out_accept, out_err;
  logic [FV_W-1:0] in_feat;
  logic [7:0]      mem_addr;
  logic [31:0]     mem_data;
`ifdef DT_DEPTH_EN
  logic [7:0]      out_depth;
`endif

  dt_walker dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_accept(out_accept),
`ifdef DT_DEPTH_EN
    .out_depth(out_depth),
`endif
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Registered node memory model
  logic [31:0] rom [256];
  always_ff @(posedge clk) mem_data <= rom[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic acc; logic err; int lat; int depth; int hs;} exp_t;
  exp_t sb[$];
  exp_t me;
  bit   seen = 0;
  int   tests = 0, failed = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] nd(input logic [3:0] idx, input logic [15:0] thr,
                                     input logic [3:0] lc, input logic [7:0] rc);
    return {idx, thr, lc, rc};
  endfunction

  // Monitor: compare once per verdict at its first valid cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !seen) begin
        seen = 1;
        if (sb.size() == 0) chk("unexpected_verdict", 1, 0);
        else begin
          me = sb.pop_front();
          chk("accept", int'(out_accept), int'(me.acc));
          chk("err", int'(out_err), int'(me.err));
          chk("latency", cyc - me.hs, me.lat);
`ifdef DT_DEPTH_EN
          chk("depth", int'(out_depth), me.depth);
`endif
        end
      end
      if (out_valid && out_ready) seen = 0;
    end
  end

  task automatic issue(input logic [FV_W-1:0] f, input logic acc, input logic err,
                       input int lat, input int depth, input bit expect_out);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_feat  = f;
    in_valid = 1'b1;
    e.acc = acc; e.err = err; e.lat = lat; e.depth = depth; e.hs = cyc;
    if (expect_out) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_feat  = '1;  // captured copy must be used from here on
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("verdict_timeout", 0, 1);
      sb.delete();
    end
  endtask

  logic [FV_W-1:0] f;
  logic            acc0, err0;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0]  = nd(4'd2, 16'd100, 4'd0, 8'd72);
    rom[1]  = nd(4'd0, 16'd5, 4'd0, 8'd63);
    for (int i = 2; i <= 6; i++) rom[i] = nd(4'd1, 16'd1, 4'd0, 8'd12);
    rom[7]  = nd(4'hF, 16'd0, 4'hF, 8'd0);
    rom[12] = nd(4'hF, 16'd0, 4'h0, 8'd0);
    rom[63] = nd(4'd6, 16'd1, 4'd0, 8'd64);
    for (int i = 64; i <= 66; i++) rom[i] = nd(4'd1, 16'd1, 4'd0, 8'd12);
    rom[67] = nd(4'd13, 16'd600, 4'd0, 8'd12);
    rom[72] = nd(4'd3, 16'd1, 4'd7, 8'd0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_feat = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_accept", int'(out_accept), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    rst = 1'b0;

    // Path 0..7, accept, depth 7
    f = '0;
    issue(f, 1'b1, 1'b0, 17, 7, 1'b1);
    drain();

    // Path 0,1,63..67,12, drop, depth 7
    f = '0;
    f[0*FEAT_W +: FEAT_W]  = 16'd5;
    f[6*FEAT_W +: FEAT_W]  = 16'd1;
    f[13*FEAT_W +: FEAT_W] = 16'd600;
    issue(f, 1'b0, 1'b0, 17, 7, 1'b1);
    drain();

    // Path 0,72,7 via direct left code, depth 2
    f = '0;
    f[2*FEAT_W +: FEAT_W] = 16'd100;
    issue(f, 1'b1, 1'b0, 7, 2, 1'b1);
    drain();

    // Backpressure: verdict held while out_ready low
    out_ready = 1'b0;
    f = '0;
    issue(f, 1'b1, 1'b0, 17, 7, 1'b1);
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    chk("bp_valid_seen", int'(out_valid), 1);
    acc0 = out_accept; err0 = out_err;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_accept_stable", int'(out_accept), int'(acc0));
      chk("bp_err_stable", int'(out_err), int'(err0));
      chk("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    drain();

    // Reset mid-walk discards the walk
    f = '0;
    issue(f, 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_mem_addr", int'(mem_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("midrst_no_verdict", int'(out_valid), 0);
    chk("midrst_idle", int'(in_ready), 1);

    // Bad feature index 4'hE at node 0
    rom[0] = nd(4'hE, 16'd0, 4'd0, 8'd1);
    issue('0, 1'b0, 1'b1, 3, 0, 1'b1);
    drain();

    // Right child 200 is out of range
    rom[0] = nd(4'd0, 16'd0, 4'd0, 8'd200);
    issue('0, 1'b0, 1'b1, 3, 1, 1'b1);
    drain();

    // Self loop on node 0 hits the step limit after 16 evaluations
    rom[0] = nd(4'd0, 16'd0, 4'd0, 8'd0);
    issue('0, 1'b0, 1'b1, 33, 16, 1'b1);
    drain();

    // Recovery with the real tree
    rom[0] = nd(4'd2, 16'd100, 4'd0, 8'd72);
    f = '0;
    f[2*FEAT_W +: FEAT_W] = 16'd100;
    issue(f, 1'b1, 1'b0, 7, 2, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dt_walker.md
Name: dt_walker

Overview:
- Traversal engine for the decision-tree classifier. It sits directly downstream of the node memory: it drives the memory's `addr` and consumes the registered 32-bit node word.
- It accepts one flat feature vector per packet and walks the tree from node 0 to a leaf. It emits an ACCEPT/DROP verdict through a valid/ready handshake.

Parameters:
- N_FEAT, 14, number of 16-bit features per packet (indices 0..N_FEAT-1)
- FEAT_W, 16, feature/threshold width
- N_NODES, 73, number of valid node addresses (0..N_NODES-1)
- MAX_STEPS, 16, maximum internal-node evaluations before abort

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine idle, can take a vector
- in_feat  in  N_FEAT*FEAT_W  feature i at bits [i*FEAT_W +: FEAT_W]
- mem_addr  out  8  node address to node memory
- mem_data  in  32  node word, valid one cycle after mem_addr
- out_valid  out  1  verdict valid
- out_ready  in  1  consumer takes verdict
- out_accept  out  1  1=ACCEPT, 0=DROP
- out_err  out  1  abort: bad feature index, bad address or step limit

Behaviour:
- Node word fields:
  - [31:28] feature index; 4'hF marks a leaf.
  - [27:12] unsigned threshold.
  - [11:8] left code: 0 = addr+1, otherwise the direct left address 0..15.
  - [7:0] right child address.
  - Leaf: [11:8]==4'hF means ACCEPT; any other value means DROP.
- Decision: in_feat[idx] < threshold (unsigned) goes left; otherwise right.
- Reset values: state IDLE, mem_addr 0, in_ready 1, out_valid 0, out_accept 0, out_err 0, step counter 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_feat, set node=0 and steps=0, then go to FETCH. in_feat is ignored after capture.
  - FETCH: mem_addr=node (registered). Wait one cycle for memory latency, then go to EVAL.
  - EVAL: mem_data belongs to node.
    - Leaf: out_accept per leaf code, out_err=0, go to DONE.
    - Feature index >= N_FEAT (non-leaf): out_accept=0, out_err=1, go to DONE.
    - Otherwise compute the next address and increment steps.
      - Next address >= N_NODES, or steps reaches MAX_STEPS: out_accept=0, out_err=1, go to DONE.
      - Else node=next, go to FETCH.
  - DONE: out_valid=1. out_accept and out_err are held stable until out_ready. On out_valid&out_ready, go to IDLE; in_ready rises the next cycle.
- Latency from input handshake to out_valid: 2*(D+1)+1 cycles, where D is the number of internal nodes evaluated.
- Addr+1 arithmetic is 8-bit; a result of 255+1 wraps to 0. The N_NODES check still applies.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- rst mid-walk returns to reset values immediately; the walk in progress is discarded and produces no verdict.

Optional Feature:
- Macro DT_DEPTH_EN.
- Defined: adds port out_depth (out, 8), giving the internal-node evaluation count D of the current verdict. It is valid with out_valid and 0 at reset.
- Undefined: the port and its counter output are absent; the step counter is used only for the MAX_STEPS check.

Test Plan (engine wired to the team's node memory):
- All features 0 -> path 0,1,2,3,4,5,6,7. out_valid 17 cycles after handshake, out_accept=1, out_err=0 (depth 7).
- f0=5, f6=1, f13=600, rest 0 -> path 0,1,63,64,65,66,67,12. out_accept=0, out_err=0, latency 17.
- f2=100, rest 0 -> path 0,72,7. out_accept=1, latency 7 (depth 2).
- Stub memory returning a word with index 4'hE, then a separate run with right child 200 -> out_accept=0, out_err=1 in both cases.
- Stub memory self-looping on node 0 (right=0, feature always >= threshold) -> abort after 16 evaluations, out_err=1.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and verdict stable, in_ready=0. Also assert rst mid-walk -> out_valid stays 0 and in_ready=1 after reset.
